// File: rtl/io_check_sequencer_if.sv
// Bundle between the io_check_sequencer and its environment: vector table writes, DUT stimulus/response and run results.
// The master modport drives the table, start and DUT segments; the slave modport belongs to the sequencer.
interface io_check_sequencer_if #(
    parameter int NUM_DIGITS  = 8,
    parameter int SW_WIDTH    = 18,
    parameter int NUM_VECTORS = 4
);
    localparam int AW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int CW = $clog2(NUM_VECTORS + 1);

    logic                      start;
    logic                      vec_we;
    logic [AW-1:0]             vec_addr;
    logic [SW_WIDTH-1:0]       vec_sw;
    logic [NUM_DIGITS*5-1:0]   vec_exp;
    logic [NUM_DIGITS*7-1:0]   hex_in;
    logic [SW_WIDTH-1:0]       sw_out;
    logic                      dut_rst_n;
    logic                      busy;
    logic                      done;
    logic [CW-1:0]             pass_count;
    logic [CW-1:0]             fail_count;
    logic [AW-1:0]             first_fail_idx;
    logic                      first_fail_valid;
    logic [NUM_DIGITS-1:0]     mismatch_mask;

    modport master (
        output start, vec_we, vec_addr, vec_sw, vec_exp, hex_in,
        input  sw_out, dut_rst_n, busy, done, pass_count, fail_count,
               first_fail_idx, first_fail_valid, mismatch_mask
    );

    modport slave (
        input  start, vec_we, vec_addr, vec_sw, vec_exp, hex_in,
        output sw_out, dut_rst_n, busy, done, pass_count, fail_count,
               first_fail_idx, first_fail_valid, mismatch_mask
    );
endinterface

// File: rtl/io_check_sequencer.sv
// Table-driven stimulus/response checker: resets the DUT, applies switch vectors, decodes and checks HEX digits.
// Latency: done rises 1+RST_CYCLES+NUM_VECTORS*(SETTLE_CYCLES+2) edges after start; start/table writes ignored while busy.
// IO_CHECK_STOP_ON_FAIL_EN: when defined, the first failing vector ends the run early.
module io_check_sequencer #(
    parameter int NUM_DIGITS    = 8,
    parameter int SW_WIDTH      = 18,
    parameter int NUM_VECTORS   = 4,
    parameter int SETTLE_CYCLES = 20,
    parameter int RST_CYCLES    = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 rst,
    io_check_sequencer_if.slave  io
);
    localparam int AW  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int CW  = $clog2(NUM_VECTORS + 1);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RST_DUT, APPLY, WAIT, CHECK, DONE} state_t;

    state_t                    state;
    logic [SW_WIDTH-1:0]       tbl_sw  [NUM_VECTORS];
    logic [NUM_DIGITS*5-1:0]   tbl_exp [NUM_VECTORS];
    logic [AW-1:0]             k;
    logic [RCW-1:0]            rcnt;
    logic [SCW-1:0]            scnt;
    logic [NUM_DIGITS*7-1:0]   hex_q;
    logic [NUM_DIGITS*5-1:0]   cur_exp;
    logic [NUM_DIGITS-1:0]     mism;
    logic                      last;
    logic                      stop;

    // Invalid patterns always mismatch; an expected blank only accepts the all-off pattern.
    function automatic logic digit_mismatch(input logic [6:0] seg, input logic [4:0] exp_d);
        logic [4:0] code;
        logic       valid;
        valid = 1'b1;
        case (seg)
            7'h40: code = 5'h00;
            7'h79: code = 5'h01;
            7'h24: code = 5'h02;
            7'h30: code = 5'h03;
            7'h19: code = 5'h04;
            7'h12: code = 5'h05;
            7'h02: code = 5'h06;
            7'h78: code = 5'h07;
            7'h00: code = 5'h08;
            7'h10: code = 5'h09;
            7'h08: code = 5'h0a;
            7'h03: code = 5'h0b;
            7'h46: code = 5'h0c;
            7'h21: code = 5'h0d;
            7'h06: code = 5'h0e;
            7'h0e: code = 5'h0f;
            7'h7f: code = 5'h10;
            default: begin
                code  = 5'h00;
                valid = 1'b0;
            end
        endcase
        if (!valid)
            digit_mismatch = 1'b1;
        else if (exp_d[4])
            digit_mismatch = !code[4];
        else
            digit_mismatch = (code != {1'b0, exp_d[3:0]});
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (io.vec_we && !io.busy && (32'(io.vec_addr) < NUM_VECTORS)) begin
            tbl_sw[io.vec_addr]  <= io.vec_sw;
            tbl_exp[io.vec_addr] <= io.vec_exp;
        end
    end

    assign cur_exp = tbl_exp[k];
    assign last    = (32'(k) == NUM_VECTORS - 1);

    always_comb begin
        mism = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            mism[i] = digit_mismatch(hex_q[7*i +: 7], cur_exp[5*i +: 5]);
    end

`ifdef IO_CHECK_STOP_ON_FAIL_EN
    assign stop = last || (|mism);
`else
    assign stop = last;
`endif

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            io.sw_out           <= '0;
            io.dut_rst_n        <= 1'b0;
            io.busy             <= 1'b0;
            io.done             <= 1'b0;
            io.pass_count       <= '0;
            io.fail_count       <= '0;
            io.first_fail_idx   <= '0;
            io.first_fail_valid <= 1'b0;
            io.mismatch_mask    <= '0;
            k                   <= '0;
            rcnt                <= '0;
            scnt                <= '0;
            hex_q               <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    io.dut_rst_n <= 1'b1;
                    if (io.start) begin
                        io.pass_count       <= '0;
                        io.fail_count       <= '0;
                        io.mismatch_mask    <= '0;
                        io.first_fail_valid <= 1'b0;
                        io.done             <= 1'b0;
                        io.busy             <= 1'b1;
                        io.sw_out           <= tbl_sw[0];
                        rcnt                <= '0;
                        state               <= RST_DUT;
                    end
                end
                // One idle edge after start, then RST_CYCLES edges with the DUT held in reset.
                RST_DUT: begin
                    if (rcnt == RCW'(RST_CYCLES)) begin
                        io.dut_rst_n <= 1'b1;
                        io.sw_out    <= tbl_sw[0];
                        k            <= '0;
                        state        <= APPLY;
                    end else begin
                        io.dut_rst_n <= 1'b0;
                        rcnt         <= rcnt + 1'b1;
                    end
                end
                APPLY: begin
                    scnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (scnt == SCW'(SETTLE_CYCLES - 1)) begin
                        hex_q <= io.hex_in;
                        state <= CHECK;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                CHECK: begin
                    io.mismatch_mask <= mism;
                    if (|mism) begin
                        io.fail_count <= io.fail_count + 1'b1;
                        if (!io.first_fail_valid) begin
                            io.first_fail_idx   <= k;
                            io.first_fail_valid <= 1'b1;
                        end
                    end else begin
                        io.pass_count <= io.pass_count + 1'b1;
                    end
                    if (stop) begin
                        io.done <= 1'b1;
                        io.busy <= 1'b0;
                        state   <= DONE;
                    end else begin
                        io.sw_out <= tbl_sw[k + 1'b1];
                        k         <= k + 1'b1;
                        state     <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_check_sequencer.sv
// Directed bench for io_check_sequencer: a loopback model shows sw_out as hex digits (upper digits blank)
// with per-digit overrides to inject blank or invalid patterns.
module tb_io_check_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_check_sequencer_if bus ();
    io_check_sequencer dut (.CLOCK_50(clk), .rst(rst), .io(bus));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  frc_en  = 8'h00;
    logic [6:0]  frc_val = 7'h7f;
    logic [55:0] hex_model;

    localparam logic [17:0] V0 = 18'h1dddd;
    localparam logic [17:0] V1 = 18'h2a5f0;
    localparam logic [17:0] V2 = 18'h01234;
    localparam logic [17:0] V3 = 18'h3c9b7;

`ifdef IO_CHECK_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;  4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;  4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;  4'ha: seg_of = 7'h08;  4'hb: seg_of = 7'h03;
            4'hc: seg_of = 7'h46;  4'hd: seg_of = 7'h21;  4'he: seg_of = 7'h06;  default: seg_of = 7'h0e;
        endcase
    endfunction

    function automatic logic [39:0] mk_exp(input logic [17:0] sw);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[5*i +: 5] = {1'b0, sw[4*i +: 4]};
        r[24:20] = {3'b000, sw[17:16]};
        for (int i = 5; i < 8; i++) r[5*i +: 5] = 5'h10;
        return r;
    endfunction

    always_comb begin
        hex_model = {8{7'h7f}};
        for (int i = 0; i < 4; i++) hex_model[7*i +: 7] = seg_of(bus.sw_out[4*i +: 4]);
        hex_model[34:28] = seg_of({2'b00, bus.sw_out[17:16]});
        for (int i = 0; i < 8; i++)
            if (frc_en[i]) hex_model[7*i +: 7] = frc_val;
    end
    assign bus.hex_in = hex_model;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic write_vec(input int idx, input logic [17:0] sw, input logic [39:0] ex);
        bus.vec_addr = 2'(idx);
        bus.vec_sw   = sw;
        bus.vec_exp  = ex;
        bus.vec_we   = 1'b1;
        @(posedge clk); #1;
        bus.vec_we   = 1'b0;
    endtask

    task automatic load_defaults();
        write_vec(0, V0, mk_exp(V0));
        write_vec(1, V1, mk_exp(V1));
        write_vec(2, V2, mk_exp(V2));
        write_vec(3, V3, mk_exp(V3));
    endtask

    // Pulse start (sampled at edge 0) and return the edge number at which done is first seen.
    task automatic run(output int e);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        e = 0;
        do begin
            @(posedge clk); #1;
            e++;
        end while (!bus.done && e < 300);
    endtask

    int e;
    logic [39:0] ex;

    initial begin
        bus.start = 1'b0; bus.vec_we = 1'b0; bus.vec_addr = '0; bus.vec_sw = '0; bus.vec_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sw_out", 64'(bus.sw_out), 0);
        chk("rst_dut_rst_n", 64'(bus.dut_rst_n), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_counts", 64'({bus.pass_count, bus.fail_count}), 0);
        chk("rst_ff", 64'({bus.first_fail_valid, bus.first_fail_idx}), 0);
        chk("rst_mask", 64'(bus.mismatch_mask), 0);
        rst = 1'b0;
        load_defaults();
        chk("idle_dut_rst_n", 64'(bus.dut_rst_n), 1);

        // Cycle-exact run with an ignored second start and an ignored write while busy.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_sw_out", 64'(bus.sw_out), 64'(V0));
        for (int i = 1; i <= 91; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                chk("e1_dut_rst_n", 64'(bus.dut_rst_n), 0);
                chk("e1_busy", 64'(bus.busy), 1);
            end
            if (i == 2) chk("e2_dut_rst_n", 64'(bus.dut_rst_n), 0);
            if (i == 3) chk("e3_dut_rst_n", 64'(bus.dut_rst_n), 1);
            if (i == 26) chk("e26_sw_out", 64'(bus.sw_out), 64'(V1));
            if (i == 39) bus.start = 1'b1;
            if (i == 40) bus.start = 1'b0;
            if (i == 49) begin
                bus.vec_addr = 2'd3; bus.vec_sw = '0; bus.vec_exp = '0; bus.vec_we = 1'b1;
            end
            if (i == 50) bus.vec_we = 1'b0;
            if (i == 90) chk("e90_done", 64'(bus.done), 0);
        end
        chk("e91_done", 64'(bus.done), 1);
        chk("e91_busy", 64'(bus.busy), 0);
        chk("t1_pass", 64'(bus.pass_count), 4);
        chk("t1_fail", 64'(bus.fail_count), 0);
        chk("t1_mask", 64'(bus.mismatch_mask), 0);
        chk("t1_ffv", 64'(bus.first_fail_valid), 0);

        // HEX2 forced blank on every vector.
        frc_en = 8'h04; frc_val = 7'h7f;
        run(e);
        chk("t2_lat", 64'(e), STOP_EN ? 25 : 91);
        chk("t2_pass", 64'(bus.pass_count), 0);
        chk("t2_fail", 64'(bus.fail_count), STOP_EN ? 1 : 4);
        chk("t2_mask", 64'(bus.mismatch_mask), 64'h04);
        chk("t2_ff", 64'({bus.first_fail_valid, bus.first_fail_idx}), 64'h4);

        // Invalid pattern on digit 0.
        frc_en = 8'h01; frc_val = 7'h55;
        run(e);
        chk("t3_mask", 64'(bus.mismatch_mask), 64'h01);
        chk("t3_fail", 64'(bus.fail_count), STOP_EN ? 1 : 4);

        // Blank shown on digit 0 with blank expected.
        frc_val = 7'h7f;
        ex = mk_exp(V0); ex[4:0] = 5'h10; write_vec(0, V0, ex);
        ex = mk_exp(V1); ex[4:0] = 5'h10; write_vec(1, V1, ex);
        ex = mk_exp(V2); ex[4:0] = 5'h10; write_vec(2, V2, ex);
        ex = mk_exp(V3); ex[4:0] = 5'h10; write_vec(3, V3, ex);
        run(e);
        chk("t4_lat", 64'(e), 91);
        chk("t4_pass", 64'(bus.pass_count), 4);
        chk("t4_mask", 64'(bus.mismatch_mask), 0);

        // Vector 1 expects 6 on digit 2 but the loopback shows 5.
        frc_en = 8'h00;
        load_defaults();
        ex = mk_exp(V1); ex[14:10] = 5'h06; write_vec(1, V1, ex);
        run(e);
        chk("t5_lat", 64'(e), STOP_EN ? 47 : 91);
        chk("t5_pass", 64'(bus.pass_count), STOP_EN ? 1 : 3);
        chk("t5_fail", 64'(bus.fail_count), 1);
        chk("t5_ff", 64'({bus.first_fail_valid, bus.first_fail_idx}), 64'h5);
        chk("t5_mask", 64'(bus.mismatch_mask), STOP_EN ? 64'h04 : 64'h00);

        // Reset in the middle of vector 1's WAIT, then a clean rerun.
        write_vec(1, V1, mk_exp(V1));
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (29) begin @(posedge clk); #1; end
        chk("t6_pass_pre", 64'(bus.pass_count), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_busy", 64'(bus.busy), 0);
        chk("t6_done", 64'(bus.done), 0);
        chk("t6_counts", 64'({bus.pass_count, bus.fail_count}), 0);
        chk("t6_dut_rst_n", 64'(bus.dut_rst_n), 0);
        chk("t6_sw_out", 64'(bus.sw_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(e);
        chk("t7_lat", 64'(e), 91);
        chk("t7_pass", 64'(bus.pass_count), 4);
        chk("t7_fail", 64'(bus.fail_count), 0);
        chk("t7_ffv", 64'(bus.first_fail_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/io_check_sequencer.md
Name: io_check_sequencer

Overview:
- Parametrised, self-checking stimulus/response sequencer for the CPU simulation top.
- Holds a table of switch vectors and expected seven-segment digits, and resets the DUT once per run.
- For each vector it drives the switches, waits a programmable number of cycles, then samples and decodes the HEX outputs.
- Reports pass/fail counts, a per-digit mismatch mask and the index of the first failing vector.
- Replaces fixed-delay, hand-written HEX checks in simtop with one table-driven, cycle-exact block.

Parameters:
- NUM_DIGITS, 8, number of seven-segment digits checked (HEX0..HEX(NUM_DIGITS-1)).
- SW_WIDTH, 18, switch vector width.
- NUM_VECTORS, 4, vector table depth (>=1).
- SETTLE_CYCLES, 20, WAIT-state cycles per vector (>=1).
- RST_CYCLES, 2, cycles DUT reset is held low at run start (>=1).

Ports:
- CLOCK_50  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request.
- vec_we  in  1  vector table write enable.
- vec_addr  in  $clog2(NUM_VECTORS)  table write index.
- vec_sw  in  SW_WIDTH  switch value to store.
- vec_exp  in  NUM_DIGITS*5  expected digits, digit i at [5i+4:5i]; bit4=blank, bits3:0=hex value.
- hex_in  in  NUM_DIGITS*7  DUT segments, digit i at [7i+6:7i], active-low, bit0=a .. bit6=g.
- sw_out  out  SW_WIDTH  switches driven to DUT.
- dut_rst_n  out  1  active-low DUT reset (drives KEY[0]).
- busy  out  1  run in progress.
- done  out  1  run complete.
- pass_count  out  $clog2(NUM_VECTORS+1)  vectors passed.
- fail_count  out  $clog2(NUM_VECTORS+1)  vectors failed.
- first_fail_idx  out  $clog2(NUM_VECTORS)  index of the first failing vector.
- first_fail_valid  out  1  first_fail_idx is meaningful.
- mismatch_mask  out  NUM_DIGITS  per-digit mismatch of the most recent CHECK.

Behaviour:
- Reset values:
  - sw_out=0, dut_rst_n=0, busy=0, done=0.
  - All counts, first_fail_idx, first_fail_valid and mismatch_mask = 0.
  - FSM=IDLE. Vector table contents are not reset.
- Table writes: accepted only when busy=0; written at the clock edge. Writes while busy=1 are ignored.
- FSM, one transition per edge:
  - IDLE:
    - dut_rst_n=1.
    - On start=1: clear counts, mask, first_fail_valid and done; load sw_out=vec[0]; go RST_DUT.
  - RST_DUT: dut_rst_n=0 for exactly RST_CYCLES cycles, then go APPLY with index k=0.
  - APPLY: one cycle; sw_out=vec[k].sw.
  - WAIT: SETTLE_CYCLES cycles; hex_in is registered on the last WAIT edge.
  - CHECK: one cycle; compare the registered sample with vec[k].exp.
    - Update mask; increment pass_count or fail_count.
    - On the first failure: set first_fail_idx=k and first_fail_valid=1.
    - If k==NUM_VECTORS-1, go DONE; otherwise k++ and go APPLY.
  - DONE:
    - done=1, busy=0, dut_rst_n=1.
    - sw_out, counts and mask are held until the next start or rst.
    - start in DONE begins a new run, identical to start in IDLE.
- busy=1 in every state from RST_DUT through CHECK.
- start while busy=1 is ignored.
- Decode (active-low segment patterns):
  - Digits: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
  - Blank: 7F.
  - Any other pattern is invalid and always mismatches.
  - Expected blank matches only 7F.
- Run latency: done rises at edge 1+RST_CYCLES+NUM_VECTORS*(SETTLE_CYCLES+2) after the edge that sampled start. Defaults give 91.
- Counters cannot overflow; their width covers NUM_VECTORS.
- rst mid-run: immediate return to reset values. dut_rst_n goes low asynchronously.

Optional Feature:
- Macro: IO_CHECK_STOP_ON_FAIL_EN.
- Defined: the first CHECK with any mismatch goes directly to DONE. Remaining vectors are not applied and counts reflect only the vectors checked.
- Undefined: all NUM_VECTORS vectors are always run.

Test Plan:
- Loopback model displays sw as hex, upper digits blank; one vector sw=18'h1dddd, exp digits0-4 = D,D,D,D,1, digits5-7 blank -> pass_count=1, fail_count=0, mask=0, done=1.
- Same vector with model forcing HEX2=7F -> fail_count=1, mask=8'b00000100, first_fail_idx=0, first_fail_valid=1.
- hex_in digit0=55 (invalid) with any expected value -> mask bit0=1. Digit0=7F with blank expected -> mask bit0=0.
- Defaults with 4 vectors; start pulsed at edge 0 -> dut_rst_n low for edges 1-2; done rises exactly at edge 91; second start pulsed at edge 40 is ignored.
- rst asserted at edge 30 (mid-WAIT) -> busy=0, done=0, counts=0, dut_rst_n=0 in the same cycle. Following start runs from vector 0.
- IO_CHECK_STOP_ON_FAIL_EN defined, vector 1 failing -> done after the second CHECK (edge 47), pass=1, fail=1, first_fail_idx=1. Undefined -> done at edge 91, pass=3, fail=1.
